// File: rtl/median_filter_stream.sv
// Streaming sliding-window median filter (WIN samples, signed), one result per accepted sample.
// Two-stage pipeline: rank every window slot, then select rank M (or the centre slot in pass-through).
module median_filter_stream #(
    parameter int WIDTH = 16,
    parameter int WIN   = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAR,
    input  logic             MODE,
    input  logic             DIN_VALID,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             DOUT_VALID,
    output logic [WIDTH-1:0] DATA_OUT
);
    localparam int M  = (WIN - 1) / 2;
    localparam int RW = $clog2(WIN);
    localparam int FW = $clog2(WIN + 1);

    if (WIN < 3 || WIN > 15 || (WIN % 2) == 0) begin : g_bad_win
        $error("median_filter_stream: WIN must be odd and within 3..15");
    end

    logic signed [WIDTH-1:0] win_q [WIN];
    logic [FW-1:0]           fill_q;
    logic                    acc_q;
    logic                    acc_mode_q;
    logic                    full_next;

    logic signed [WIDTH-1:0] s1_win [WIN];
    logic [RW-1:0]           s1_rank [WIN];
    logic                    s1_mode;
    logic                    s1_valid;

    logic [RW-1:0]           rank_d [WIN];
    logic signed [WIDTH-1:0] sel_d;

    // The incoming sample completes a full window if WIN-1 were already held.
    assign full_next = (fill_q >= FW'(WIN - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
            fill_q     <= '0;
            acc_q      <= 1'b0;
            acc_mode_q <= 1'b0;
        end else if (CLEAR) begin
            for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
            fill_q     <= '0;
            acc_q      <= 1'b0;
            acc_mode_q <= MODE;
        end else begin
            acc_q      <= DIN_VALID && full_next;
            acc_mode_q <= MODE;
            if (DIN_VALID) begin
                win_q[0] <= $signed(DATA_IN);
                for (int unsigned i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
                if (fill_q != FW'(WIN)) fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Ties broken by slot index so the ranks are always a permutation.
    always_comb begin
        for (int unsigned i = 0; i < WIN; i++) begin
            rank_d[i] = '0;
            for (int unsigned j = 0; j < WIN; j++) begin
                if ((win_q[j] < win_q[i]) || ((j < i) && (win_q[j] == win_q[i])))
                    rank_d[i] = rank_d[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                s1_win[i]  <= '0;
                s1_rank[i] <= '0;
            end
            s1_mode  <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIN; i++) begin
                s1_win[i]  <= win_q[i];
                s1_rank[i] <= rank_d[i];
            end
            s1_mode  <= acc_mode_q;
            s1_valid <= acc_q && !CLEAR;
        end
    end

    always_comb begin
        sel_d = s1_win[M];
        if (!s1_mode) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                if (s1_rank[i] == RW'(M)) sel_d = s1_win[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT_VALID <= 1'b0;
            DATA_OUT   <= '0;
        end else begin
            DOUT_VALID <= s1_valid && !CLEAR;
            if (s1_valid && !CLEAR) DATA_OUT <= sel_d;
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Bench for median_filter_stream: WIN=3/5/15 instances share one input stream and are
// checked against a sorting reference through a due-cycle scoreboard.
module tb_median_filter_stream;

    typedef struct {
        int          inst;
        logic [15:0] val;
        int          due;
    } exp_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        logic        m;
    } stim_t;

    logic        CLK;
    logic        RST_N;
    logic        CLEAR;
    logic        MODE;
    logic        DIN_VALID;
    logic [15:0] DATA_IN;
    logic        dv [3];
    logic [15:0] dq [3];

    int          wins [3] = '{3, 5, 15};
    logic signed [15:0] mw [3][15];
    int          mfill [3];
    logic [15:0] last [3];
    exp_t        sbq [$];
    stim_t       stim [$];
    logic [15:0] got [$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    median_filter_stream #(.WIDTH(16), .WIN(3)) u_w3 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .MODE(MODE), .DIN_VALID(DIN_VALID),
        .DATA_IN(DATA_IN), .DOUT_VALID(dv[0]), .DATA_OUT(dq[0]));
    median_filter_stream #(.WIDTH(16), .WIN(5)) u_w5 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .MODE(MODE), .DIN_VALID(DIN_VALID),
        .DATA_IN(DATA_IN), .DOUT_VALID(dv[1]), .DATA_OUT(dq[1]));
    median_filter_stream #(.WIDTH(16), .WIN(15)) u_w15 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .MODE(MODE), .DIN_VALID(DIN_VALID),
        .DATA_IN(DATA_IN), .DOUT_VALID(dv[2]), .DATA_OUT(dq[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            mfill[i] = 0;
            for (int k = 0; k < 15; k++) mw[i][k] = '0;
        end
    endtask

    task automatic model_accept(input int i, input logic [15:0] d, input logic m);
        int n;
        logic signed [15:0] s [15];
        logic signed [15:0] t;
        exp_t e;
        n = wins[i];
        for (int k = n - 1; k > 0; k--) mw[i][k] = mw[i][k-1];
        mw[i][0] = d;
        if (mfill[i] < n) mfill[i]++;
        if (mfill[i] == n) begin
            for (int k = 0; k < n; k++) s[k] = mw[i][k];
            for (int a = 0; a < n - 1; a++)
                for (int b = 0; b < n - 1 - a; b++)
                    if (s[b] > s[b+1]) begin
                        t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                    end
            e.inst = i;
            e.val  = m ? mw[i][(n-1)/2] : s[(n-1)/2];
            e.due  = cyc + 2;
            sbq.push_back(e);
        end
    endtask

    // Drives one cycle, updates the reference at the edge, returns 1 time unit after it.
    task automatic step(input logic v, input logic [15:0] d, input logic c, input logic m);
        DIN_VALID = v;
        DATA_IN   = d;
        CLEAR     = c;
        MODE      = m;
        @(posedge CLK);
        cyc++;
        if (c) model_reset();
        else if (v) for (int i = 0; i < 3; i++) model_accept(i, d, m);
        #1;
    endtask

    task automatic sb_take(input int i, output logic ev, output logic [15:0] ed);
        ev = 1'b0;
        ed = last[i];
        for (int k = 0; k < sbq.size(); k++) begin
            if (sbq[k].inst == i && sbq[k].due == cyc) begin
                ev = 1'b1;
                ed = sbq[k].val;
                sbq.delete(k);
                break;
            end
        end
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic c, input logic m);
        stim_t s;
        s.v = v; s.d = d; s.c = c; s.m = m;
        stim.push_back(s);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLEAR = 1'b0; MODE = 1'b0; DIN_VALID = 1'b0; DATA_IN = '0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < 3; i++) last[i] = '0;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dv[i] !== 1'b0 || dq[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset w%0d: got valid=%b data=%h, expected valid=0 data=0000",
                         wins[i], dv[i], dq[i]);
            end
        end
        RST_N = 1'b1;
    endtask

    task automatic test_warmup_basic();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'd10};
        logic ok;
        stim.delete(); got.delete();
        add(1, 16'd10, 0, 0); add(1, 16'd50, 0, 0); add(1, -16'sd3, 0, 0);
        add(1, 16'd7, 0, 0);  add(1, 16'd100, 0, 0);
        repeat (3) add(0, '0, 0, 0);
        foreach (stim[s]) begin
            step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL warmup w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
            if (dv[1] === 1'b1) got.push_back(dq[1]);
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL warmup_values: got %0d results (first %0d), expected 1 result 10",
                     got.size(), $signed(got.size() > 0 ? got[0] : 16'h0));
        end
    endtask

    task automatic test_signed_extremes();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'd7, 16'd7};
        logic ok;
        stim.delete(); got.delete();
        add(1, 16'h8000, 0, 0); add(1, 16'h7FFF, 0, 0);
        repeat (3) add(0, '0, 0, 0);
        foreach (stim[s]) begin
            step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL extremes w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
            if (dv[1] === 1'b1) got.push_back(dq[1]);
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL extremes_values: got %0d results, expected 7 then 7", got.size());
        end
    endtask

    task automatic test_ties();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'h7FFF, 16'h7FFF};
        logic ok;
        stim.delete(); got.delete();
        add(0, '0, 1, 0);
        repeat (5) add(1, 16'h7FFF, 0, 0);
        add(1, 16'h8000, 0, 0);
        repeat (3) add(0, '0, 0, 0);
        foreach (stim[s]) begin
            step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL ties w%0d cyc %0d: got valid=%b data=%h, expected valid=%b data=%h",
                             wins[i], cyc, dv[i], dq[i], ev, ed);
                end
                last[i] = ed;
            end
            if (dv[1] === 1'b1) got.push_back(dq[1]);
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ties_values: got %0d results, expected 7fff then 7fff", got.size());
        end
    endtask

    task automatic test_gaps();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'd3, 16'd4};
        int gaps [6] = '{0, 2, 1, 3, 0, 2};
        logic ok;
        stim.delete(); got.delete();
        add(0, '0, 1, 0);
        for (int k = 0; k < 6; k++) begin
            add(1, 16'(k + 1), 0, 0);
            repeat (gaps[k]) add(0, 16'hDEAD, 0, 0);
        end
        repeat (3) add(0, '0, 0, 0);
        foreach (stim[s]) begin
            step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL gaps w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
            if (dv[1] === 1'b1) got.push_back(dq[1]);
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gaps_values: got %0d results, expected 3 then 4", got.size());
        end
    endtask

    task automatic test_clear();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'd3};
        logic ok;
        stim.delete(); got.delete();
        add(0, '0, 1, 0);
        for (int k = 1; k <= 5; k++) add(1, 16'(10 * k), 0, 0);
        add(1, 16'd99, 1, 0);
        for (int k = 1; k <= 5; k++) add(1, 16'(k), 0, 0);
        repeat (3) add(0, '0, 0, 0);
        foreach (stim[s]) begin
            step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL clear w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
            if (dv[1] === 1'b1) got.push_back(dq[1]);
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL clear_values: got %0d results, expected only 3", got.size());
        end
    endtask

    task automatic test_passthrough_reset();
        logic ev;
        logic [15:0] ed;
        logic [15:0] want [$] = '{16'd3, 16'd4, 16'd5, 16'd3};
        logic ok;
        got.delete();
        for (int phase = 0; phase < 2; phase++) begin
            stim.delete();
            if (phase == 0) begin
                add(0, '0, 1, 1);
                for (int k = 1; k <= 7; k++) add(1, 16'(k), 0, 1);
                repeat (2) add(0, '0, 0, 1);
                add(1, 16'd8, 0, 1); add(1, 16'd9, 0, 1);
            end else begin
                for (int k = 1; k <= 5; k++) add(1, 16'(k), 0, 0);
                repeat (3) add(0, '0, 0, 0);
            end
            foreach (stim[s]) begin
                step(stim[s].v, stim[s].d, stim[s].c, stim[s].m);
                for (int i = 0; i < 3; i++) begin
                    sb_take(i, ev, ed);
                    n_checks++;
                    if (dv[i] !== ev || dq[i] !== ed) begin
                        n_fail++;
                        $display("FAIL passthru w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                                 wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                    end
                    last[i] = ed;
                end
                if (dv[1] === 1'b1) got.push_back(dq[1]);
            end
            if (phase == 0) begin
                // Reset asserted between edges while results for 8 and 9 are still in flight.
                DIN_VALID = 1'b0;
                #3 RST_N = 1'b0;
                #1;
                for (int i = 0; i < 3; i++) begin
                    n_checks++;
                    if (dv[i] !== 1'b0 || dq[i] !== 16'h0000) begin
                        n_fail++;
                        $display("FAIL async_reset w%0d: got valid=%b data=%h, expected valid=0 data=0000",
                                 wins[i], dv[i], dq[i]);
                    end
                    last[i] = '0;
                end
                model_reset();
                @(posedge CLK);
                cyc++;
                #1 RST_N = 1'b1;
            end
        end
        ok = (got.size() == want.size());
        for (int k = 0; ok && k < got.size(); k++) ok = (got[k] === want[k]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL passthru_values: got %0d results, expected 3,4,5 then 3", got.size());
        end
    endtask

    task automatic test_random();
        logic ev;
        logic [15:0] ed;
        logic v, c, m;
        logic [15:0] d;
        m = 1'b0;
        for (int s = 0; s < 10000; s++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 149) == 0) m = ~m;
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom_range(0, 3));
                1:       d = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                default: d = 16'($urandom);
            endcase
            step(v, d, c, m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL random w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
        end
        repeat (3) begin
            step(1'b0, '0, 1'b0, m);
            for (int i = 0; i < 3; i++) begin
                sb_take(i, ev, ed);
                n_checks++;
                if (dv[i] !== ev || dq[i] !== ed) begin
                    n_fail++;
                    $display("FAIL random_drain w%0d cyc %0d: got valid=%b data=%0d, expected valid=%b data=%0d",
                             wins[i], cyc, dv[i], $signed(dq[i]), ev, $signed(ed));
                end
                last[i] = ed;
            end
        end
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d expected results never produced, expected 0", sbq.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_warmup_basic();
        test_signed_extremes();
        test_ties();
        test_gaps();
        test_clear();
        test_passthrough_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
